reduce_accum: RTL and testbench
===============================

// Module: reduce_accum
// PURPOSE
//   Streaming reduction stage that feeds the reduction-operator checks: accepts multi-beat packets
//   over valid/ready, folds every beat into one 1-bit result with the packet's reduction op
//   (AND/OR/XOR and their inversions), then presents the result on a registered valid/ready output.
//   Sits between a data source and any consumer of per-packet parity/all-ones/any-one flags.
// PARAMETERS
//   W      8  data beat width in bits (>=1)
//   CNT_W  8  beat-counter width (REDUCE_BEAT_CNT_EN only)
// PORTS
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      synchronous reset, active-low
//   in_valid     in   1      input beat valid
//   in_ready     out  1      stage can accept a beat
//   in_data      in   W      beat data
//   in_op        in   3      reduction op, sampled on first beat of packet only
//   in_last      in   1      final beat of packet
//   out_valid    out  1      result valid
//   out_ready    in   1      consumer accepts result
//   out_result   out  1      packet reduction result
//   out_op       out  3      op used for this result
//   out_illegal  out  1      op code was 110/111
//   out_beats    out  CNT_W  beats in packet, saturating (REDUCE_BEAT_CNT_EN only)
// BEHAVIOUR
//   - Transfer occurs when valid&&ready at a rising clk edge; no other condition moves data.
//   - Op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR; 110/111 illegal.
//   - Base op: AND for AND/NAND, OR for OR/NOR, XOR for XOR/XNOR.
//     acc <= acc BASE (BASE-reduce of in_data).
//     acc identity at packet start is 1 for AND, 0 for OR/XOR.
//   - Inverted ops (NAND/NOR/XNOR) invert acc once when the result is registered, never per beat.
//   - Illegal op: out_result=0, out_illegal=1; packet still consumed to in_last.
//   - X/Z: 4-state semantics propagate unmasked.
//     Example: AND over 3'bxxx gives x; AND over 3'b0x0 gives 0.
//   - FSM IDLE: in_ready=1.
//     Accepted beat with in_last=0: latch op, fold the beat, go to ACCUM.
//     Accepted beat with in_last=1: go to HOLD.
//   - FSM ACCUM: in_ready=1. Fold accepted beats. Accepted in_last goes to HOLD.
//   - FSM HOLD: in_ready=0, out_valid=1.
//     out_result/out_op/out_illegal are stable while out_valid && !out_ready.
//     out_ready returns to IDLE and re-arms acc to identity.
//   - Latency: result registered on the in_last edge; out_valid high in the next cycle.
//     Minimum 2 cycles per single-beat packet; no input/output overlap.
//   - in_valid=0 in ACCUM: hold state indefinitely, no timeout.
//   - Reset (any state, including mid-packet or in HOLD) takes effect on the next rising edge:
//     state=IDLE, acc=0, out_valid=0, out_result=0, out_op=0, out_illegal=0, out_beats=0.
//     The partial packet is discarded.
//   - in_ready after reset is 1.
// CONFIGURATION
//   REDUCE_BEAT_CNT_EN defined:
//     - out_beats port exists. Counts accepted beats per packet, including in_last.
//     - Saturates at 2^CNT_W-1. Latched into out_beats with the result.
//   REDUCE_BEAT_CNT_EN undefined:
//     - No out_beats port, no counter logic. All other behaviour is identical.
// STRUCTURE
//   - reduce_pkg:
//     - localparams OP_AND..OP_XNOR (3-bit)
//     - function op_identity(op)
//     - function op_is_inv(op)
//     - function op_is_legal(op)
//     - FSM state typedef {IDLE, ACCUM, HOLD}
//   - Sub-module reduce_core: combinational.
//     - Inputs: base op, acc, in_data.
//     - Output: next acc.
//     - The only place the reduction operators appear.
//   - reduce_accum holds the FSM, the acc/op registers, the output registers and the optional counter.
// TESTING
//   - Reset: hold rst_n=0 for 2 clks while in_valid=1.
//     Require out_valid=0, in_ready=1, out_result=0.
//     Require no transfer during reset.
//   - Single-beat packets (W=3), out_ready=1 throughout:
//     AND 3'b011 -> 0; OR 3'b011 -> 1; XOR 3'b011 -> 0; XNOR 3'b010 -> 0; NOR 3'b000 -> 1.
//   - Multi-beat NAND:
//     Beats 3'b111, 3'b111, 3'b101(last), with op changed to 001 on beat 2.
//     Require out_result=1, out_op=011; the op change is ignored.
//   - Backpressure:
//     Hold out_ready=0 for 5 clks after the result.
//     Require out_valid and out_result stable and in_ready=0.
//     Release out_ready: IDLE next cycle, in_ready=1.
//   - Illegal op and mid-packet reset:
//     - op=110 single beat -> out_illegal=1, out_result=0.
//     - Assert rst_n=0 after 2 of 4 beats; then a fresh XOR packet 3'b001 -> 1.
//   - X and counter:
//     - AND over 3'bxxx -> out_result x; OR over 3'b0x1 -> 1.
//     - With REDUCE_BEAT_CNT_EN and CNT_W=2: a 5-beat packet -> out_beats=3 (saturated).

Source files
------------

// File: rtl/reduce_pkg.sv
// Shared definitions for the reduce_accum streaming reduction stage:
// op encodings, op classification helpers and the FSM state type.
package reduce_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_e;

    // Underlying operator applied per beat; inversion is handled separately.
    typedef enum logic [1:0] {
        BASE_AND,
        BASE_OR,
        BASE_XOR
    } base_e;

    // Accumulator start value: all-ones family starts at 1, others at 0.
    function automatic logic op_identity(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

    function automatic logic op_is_inv(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_XNOR;
    endfunction

    function automatic base_e op_base(input logic [2:0] op);
        base_e b;
        case (op)
            OP_AND, OP_NAND: b = BASE_AND;
            OP_OR, OP_NOR:   b = BASE_OR;
            OP_XOR, OP_XNOR: b = BASE_XOR;
            default:         b = BASE_AND;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/reduce_core.sv
// Combinational fold of one data beat into the 1-bit accumulator.
// This is the only place the reduction operators are applied.
module reduce_core
    import reduce_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  base_e          base_i,
    input  logic           acc_i,
    input  logic [W-1:0]   data_i,
    output logic           acc_o
);

    // Fold: acc BASE (BASE-reduce of data); X/Z propagate with 4-state rules.
    always_comb begin
        acc_o = acc_i;
        case (base_i)
            BASE_AND: acc_o = acc_i & (&data_i);
            BASE_OR:  acc_o = acc_i | (|data_i);
            BASE_XOR: acc_o = acc_i ^ (^data_i);
            default:  acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/reduce_accum.sv
// Streaming reduction stage: folds every beat of a valid/ready packet into a
// 1-bit result using the op sampled on the first beat, then holds the result
// on a registered valid/ready output until the consumer takes it.
// Optional beat counter is enabled by defining REDUCE_BEAT_CNT_EN.
module reduce_accum
    import reduce_pkg::*;
#(
    parameter int unsigned W     = 8
`ifdef REDUCE_BEAT_CNT_EN
    ,
    parameter int unsigned CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [2:0]       out_op,
    output logic             out_illegal
`ifdef REDUCE_BEAT_CNT_EN
    ,
    output logic [CNT_W-1:0] out_beats
`endif
);

    state_e     state_q, state_d;
    logic       acc_q, acc_d;
    logic [2:0] op_q, op_d;
    logic       res_q, res_d;
    logic [2:0] out_op_q, out_op_d;
    logic       illegal_q, illegal_d;

    logic       accept;
    logic [2:0] fold_op;
    logic       acc_in;
    logic       acc_fold;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    // First beat uses the live op and its identity; later beats use the latched op.
    assign fold_op = (state_q == IDLE) ? in_op : op_q;
    assign acc_in  = (state_q == IDLE) ? op_identity(in_op) : acc_q;

    reduce_core #(
        .W (W)
    ) u_core (
        .base_i (op_base(fold_op)),
        .acc_i  (acc_in),
        .data_i (in_data),
        .acc_o  (acc_fold)
    );

    // Next-state, accumulator and result capture.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        op_d      = op_q;
        res_d     = res_q;
        out_op_d  = out_op_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d = acc_fold;
                    if (state_q == IDLE) begin
                        op_d = in_op;
                    end
                    if (in_last) begin
                        state_d   = HOLD;
                        // Inversion is applied once here, never per beat.
                        res_d     = op_is_legal(fold_op) ? (acc_fold ^ op_is_inv(fold_op)) : 1'b0;
                        out_op_d  = fold_op;
                        illegal_d = !op_is_legal(fold_op);
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = op_identity(op_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            op_q      <= OP_AND;
            res_q     <= 1'b0;
            out_op_q  <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            res_q     <= res_d;
            out_op_q  <= out_op_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_result  = res_q;
    assign out_op      = out_op_q;
    assign out_illegal = illegal_q;

`ifdef REDUCE_BEAT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0] cnt_next;

    // First beat restarts at 1; later beats saturate at all-ones.
    assign cnt_next = (state_q == IDLE) ? CNT_W'(1)
                    : ((cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1));

    // Count accepted beats and latch the total alongside the result.
    always_comb begin
        cnt_d   = cnt_q;
        beats_d = beats_q;
        if (accept) begin
            cnt_d = cnt_next;
            if (in_last) begin
                beats_d = cnt_next;
            end
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            beats_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            beats_q <= beats_d;
        end
    end

    assign out_beats = beats_q;
`endif

endmodule

// File: tb/tb_reduce_accum.sv
// Directed self-checking bench for reduce_accum (W=3; CNT_W=2 when the
// REDUCE_BEAT_CNT_EN counter is built in).
module tb_reduce_accum;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic [2:0] in_op;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic       out_result;
    logic [2:0] out_op;
    logic       out_illegal;
`ifdef REDUCE_BEAT_CNT_EN
    logic [1:0] out_beats;
`endif

    int vectors;
    int miscompares;

    reduce_accum #(
        .W     (3)
`ifdef REDUCE_BEAT_CNT_EN
        ,
        .CNT_W (2)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_op       (in_op),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_op      (out_op),
        .out_illegal (out_illegal)
`ifdef REDUCE_BEAT_CNT_EN
        ,
        .out_beats   (out_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is transferred.
    task automatic send_beat(input logic [2:0] d, input logic [2:0] op, input logic last);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_last  = last;
        while (in_ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        if (k == 20) begin
            vectors++;
            miscompares++;
            $display("FAIL send_beat: in_ready stuck at %b, required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result();
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        if (k == 10) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_result: out_valid=%b, required 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 3'b111;
        in_op     = 3'b001;
        in_last   = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset out_valid: got %b, required 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset in_ready: got %b, required 1", in_ready);
        end
        vectors++;
        if (out_result !== 1'b0) begin
            miscompares++;
            $display("FAIL reset out_result: got %b, required 0", out_result);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        step();
        // A beat offered during reset must not have produced a result.
        vectors++;
        if (out_valid !== 1'b0 || out_op !== 3'b000 || out_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset no_transfer: valid=%b op=%b ill=%b, required 0 000 0",
                     out_valid, out_op, out_illegal);
        end
    endtask

    task automatic test_single_beat();
        logic [2:0] data_t [5];
        logic [2:0] op_t   [5];
        logic       exp_t  [5];
        data_t = '{3'b011, 3'b011, 3'b011, 3'b010, 3'b000};
        op_t   = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b100};
        exp_t  = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
        for (int i = 0; i < 5; i++) begin
            send_beat(data_t[i], op_t[i], 1'b1);
            wait_result();
            vectors++;
            if (out_result !== exp_t[i] || out_op !== op_t[i] || out_illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL single[%0d]: result=%b op=%b ill=%b, required %b %b 0",
                         i, out_result, out_op, out_illegal, exp_t[i], op_t[i]);
            end
            step();
        end
    endtask

    task automatic test_multi_nand();
        send_beat(3'b111, 3'b011, 1'b0);
        send_beat(3'b111, 3'b001, 1'b0);
        send_beat(3'b101, 3'b001, 1'b1);
        wait_result();
        vectors++;
        if (out_result !== 1'b1 || out_op !== 3'b011) begin
            miscompares++;
            $display("FAIL multi_nand: result=%b op=%b, required 1 011", out_result, out_op);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(3'b001, 3'b010, 1'b1);
        wait_result();
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_result !== 1'b1 || out_op !== 3'b010
                || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: valid=%b result=%b op=%b ready=%b, required 1 1 010 0",
                         i, out_valid, out_result, out_op, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release: valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_illegal_and_reset();
        send_beat(3'b111, 3'b110, 1'b1);
        wait_result();
        vectors++;
        if (out_illegal !== 1'b1 || out_result !== 1'b0 || out_op !== 3'b110) begin
            miscompares++;
            $display("FAIL illegal: ill=%b result=%b op=%b, required 1 0 110",
                     out_illegal, out_result, out_op);
        end
        step();
        // Abandon an AND packet after 2 of 4 beats.
        send_beat(3'b111, 3'b000, 1'b0);
        send_beat(3'b111, 3'b000, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_illegal !== 1'b0
            || out_op !== 3'b000 || out_result !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b ready=%b ill=%b op=%b result=%b, required 0 1 0 000 0",
                     out_valid, in_ready, out_illegal, out_op, out_result);
        end
`ifdef REDUCE_BEAT_CNT_EN
        vectors++;
        if (out_beats !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_reset beats: got %0d, required 0", out_beats);
        end
`endif
        send_beat(3'b001, 3'b010, 1'b1);
        wait_result();
        vectors++;
        if (out_result !== 1'b1 || out_op !== 3'b010) begin
            miscompares++;
            $display("FAIL fresh_xor: result=%b op=%b, required 1 010", out_result, out_op);
        end
        step();
    endtask

    task automatic test_x_and_count();
        logic [2:0] xv;
        logic       exp_x;
        xv    = 3'bxxx;
        // All-X AND yields X under 4-state rules; follow the simulator's own semantics.
        exp_x = &xv;
        send_beat(xv, 3'b000, 1'b1);
        wait_result();
        vectors++;
        if (out_result !== exp_x) begin
            miscompares++;
            $display("FAIL and_x: got %b, required %b", out_result, exp_x);
        end
        step();
        send_beat(3'b0x1, 3'b001, 1'b1);
        wait_result();
        vectors++;
        if (out_result !== 1'b1) begin
            miscompares++;
            $display("FAIL or_x: got %b, required 1", out_result);
        end
        step();
`ifdef REDUCE_BEAT_CNT_EN
        send_beat(3'b000, 3'b001, 1'b0);
        send_beat(3'b000, 3'b001, 1'b1);
        wait_result();
        vectors++;
        if (out_beats !== 2'd2) begin
            miscompares++;
            $display("FAIL beats2: got %0d, required 2", out_beats);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            send_beat(3'b000, 3'b001, (i == 4));
        end
        wait_result();
        vectors++;
        if (out_beats !== 2'd3 || out_result !== 1'b0) begin
            miscompares++;
            $display("FAIL beats_sat: beats=%0d result=%b, required 3 0", out_beats, out_result);
        end
        step();
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 3'b000;
        in_op       = 3'b000;
        in_last     = 1'b0;
        out_ready   = 1'b1;
        test_reset();
        test_single_beat();
        test_multi_nand();
        test_backpressure();
        test_illegal_and_reset();
        test_x_and_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
